// File: rtl/lcd_ctrl_pkg.sv
// Shared types and codes for the HD44780 sequencing controller.
// Holds FSM encodings, command/row codes and the per-state transfer settings.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    StPwrup,
    StInitFs,
    StInitDon,
    StInitEm,
    StClr,
    StRow1,
    StAddr,
    StRow2,
    StRefresh
  } fsm_e;

  localparam logic [1:0] CMD_CLEAR = 2'd0;
  localparam logic [1:0] CMD_DON   = 2'd1;
  localparam logic [1:0] CMD_EM    = 2'd2;
  localparam logic [1:0] CMD_FS    = 2'd3;

  localparam logic [1:0] ROW_NUM   = 2'd0;
  localparam logic [1:0] ROW_OP    = 2'd1;
  localparam logic [1:0] ROW_BLANK = 2'd2;

  typedef struct packed {
    logic       rs;
    logic [1:0] init_sel;
    logic       data_sel;
    logic       db_sel;
    logic [1:0] row;
    logic       long_wait;
  } xfer_t;

  // Successor of each single-transfer state; row states sequence themselves.
  function automatic fsm_e next_cmd(fsm_e st);
    fsm_e nxt;
    case (st)
      StInitFs:  nxt = StInitDon;
      StInitDon: nxt = StInitEm;
      StInitEm:  nxt = StClr;
      StClr:     nxt = StRow1;
      StAddr:    nxt = StRow2;
      default:   nxt = st;
    endcase
    return nxt;
  endfunction

  // Select/RS settings presented for the whole of a transfer issued from st.
  function automatic xfer_t xfer_cfg(fsm_e st);
    xfer_t x;
    x.rs        = 1'b0;
    x.init_sel  = CMD_FS;
    x.data_sel  = 1'b0;
    x.db_sel    = 1'b1;
    x.row       = ROW_BLANK;
    x.long_wait = 1'b0;
    case (st)
      StInitDon: x.init_sel = CMD_DON;
      StInitEm:  x.init_sel = CMD_EM;
      StClr: begin
        x.init_sel  = CMD_CLEAR;
        x.long_wait = 1'b1;
      end
      StRow1: begin
        x.rs       = 1'b1;
        x.data_sel = 1'b1;
        x.row      = ROW_NUM;
      end
      // Cursor address goes through the character path with the fixed 0xCC byte.
      StAddr: begin
        x.data_sel = 1'b1;
        x.db_sel   = 1'b0;
      end
      StRow2: begin
        x.rs       = 1'b1;
        x.data_sel = 1'b1;
        x.row      = ROW_OP;
      end
      default: ;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// One LCD bus write: setup, E high, hold, then the command execution wait.
// The start cycle is the first setup cycle; done marks the last wait cycle.
module lcd_bus_timer #(
  parameter int unsigned TSU_CYC = 2,
  parameter int unsigned E_CYC   = 12,
  parameter int unsigned TH_CYC  = 1,
  parameter int unsigned CMD_CYC = 2000,
  parameter int unsigned CLR_CYC = 82000,
  parameter int unsigned CW      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic long_wait,
  output logic lcd_e,
  output logic done
);

  localparam logic [CW-1:0] ERise   = CW'(TSU_CYC);
  localparam logic [CW-1:0] EFall   = CW'(TSU_CYC + E_CYC);
  localparam logic [CW-1:0] LastCmd = CW'(TSU_CYC + E_CYC + TH_CYC + CMD_CYC - 1);
  localparam logic [CW-1:0] LastClr = CW'(TSU_CYC + E_CYC + TH_CYC + CLR_CYC - 1);

  logic          busy_q, busy_d;
  logic          long_q, long_d;
  logic          e_q, e_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] last;

  assign last  = long_q ? LastClr : LastCmd;
  assign done  = busy_q && (pos_q == last);
  assign lcd_e = e_q;

  always_comb begin
    busy_d = busy_q;
    long_d = long_q;
    pos_d  = pos_q;
    if (start) begin
      busy_d = 1'b1;
      long_d = long_wait;
      pos_d  = CW'(1);
    end else if (done) begin
      busy_d = 1'b0;
      pos_d  = '0;
    end else if (busy_q) begin
      pos_d = pos_q + CW'(1);
    end
    // E is registered from the next phase so it never glitches on the bus.
    e_d = busy_d && (pos_d >= ERise) && (pos_d < EFall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      long_q <= 1'b0;
      pos_q  <= '0;
      e_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      long_q <= long_d;
      pos_q  <= pos_d;
      e_q    <= e_d;
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Sequencer for an 8-bit HD44780 LCD: power-up wait, init, then a repeating
// frame of four digits on line 1 and four opcode characters on line 2.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned PWRUP_CYC   = 750000,
  parameter int unsigned TSU_CYC     = 2,
  parameter int unsigned E_CYC       = 12,
  parameter int unsigned TH_CYC      = 1,
  parameter int unsigned CMD_CYC     = 2000,
  parameter int unsigned CLR_CYC     = 82000,
  parameter int unsigned REFRESH_CYC = 2500000,
  parameter int unsigned BLINK_CYC   = 12500000,
  parameter int unsigned CW          = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [1:0] init_sel,
  output logic       data_sel,
  output logic       db_sel,
  output logic [1:0] state,
  output logic [1:0] index,
  output logic       blink,
  output logic       frame_done
);

  localparam logic [CW-1:0] PwrupLast   = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] RefreshLast = CW'(REFRESH_CYC - 1);
  localparam logic [CW-1:0] BlinkLast   = CW'(BLINK_CYC - 1);

  fsm_e          st_q;
  xfer_t         ctl_q;
  logic          start_q;
  logic [1:0]    index_q;
  logic [CW-1:0] tmr_q;
  logic [CW-1:0] blink_cnt_q;
  logic          blink_q;
  logic          bus_done;

  lcd_bus_timer #(
    .TSU_CYC(TSU_CYC),
    .E_CYC  (E_CYC),
    .TH_CYC (TH_CYC),
    .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC),
    .CW     (CW)
  ) u_bus_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_q),
    .long_wait(ctl_q.long_wait),
    .lcd_e    (lcd_e),
    .done     (bus_done)
  );

  assign lcd_rs     = ctl_q.rs;
  assign lcd_rw     = 1'b0;
  assign init_sel   = ctl_q.init_sel;
  assign data_sel   = ctl_q.data_sel;
  assign db_sel     = ctl_q.db_sel;
  assign state      = ctl_q.row;
  assign index      = index_q;
  assign blink      = blink_q;
  assign frame_done = bus_done && (st_q == StRow2) && (index_q == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StPwrup;
      ctl_q   <= xfer_cfg(StPwrup);
      start_q <= 1'b0;
      index_q <= 2'd3;
      tmr_q   <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (st_q)
        StPwrup, StRefresh: begin
          if (tmr_q == ((st_q == StPwrup) ? PwrupLast : RefreshLast)) begin
            tmr_q   <= '0;
            st_q    <= (st_q == StPwrup) ? StInitFs : StClr;
            ctl_q   <= xfer_cfg((st_q == StPwrup) ? StInitFs : StClr);
            start_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + CW'(1);
          end
        end
        StInitFs, StInitDon, StInitEm, StClr, StAddr: begin
          if (bus_done) begin
            st_q    <= next_cmd(st_q);
            ctl_q   <= xfer_cfg(next_cmd(st_q));
            start_q <= 1'b1;
          end
        end
        StRow1, StRow2: begin
          if (bus_done) begin
            if (index_q != 2'd0) begin
              index_q <= index_q - 2'd1;
              start_q <= 1'b1;
            end else if (st_q == StRow1) begin
              index_q <= 2'd3;
              st_q    <= StAddr;
              ctl_q   <= xfer_cfg(StAddr);
              start_q <= 1'b1;
            end else begin
              // Frame complete: idle with a blank row before the next clear.
              index_q <= 2'd3;
              tmr_q   <= '0;
              st_q    <= StRefresh;
              ctl_q   <= xfer_cfg(StRefresh);
            end
          end
        end
        default: st_q <= StPwrup;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end

endmodule
